// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - shared state type, default parameters and timer sizing for pll_lock_supervisor
package pll_sup_pkg;

    typedef enum logic [1:0] {
        S_PLLRST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN
    } pll_sup_state_t;

    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_PLLRST_CYCLES = 16;
    localparam int DEF_LOCK_TIMEOUT  = 65536;
    localparam int DEF_CNT_WIDTH     = 16;

    // One shared timer serves every state, so it must hold the largest limit minus one.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    localparam int DEF_TIMER_WIDTH = timer_width(DEF_STABLE_CYCLES, DEF_PLLRST_CYCLES, DEF_LOCK_TIMEOUT);

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser, asynchronous active-high reset to 0
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic meta;
    (* ASYNC_REG = "TRUE" *) logic sync_q;

    // Two back-to-back flops give the first stage a full cycle to resolve metastability.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta   <= d;
            sync_q <= meta;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL lock supervisor; loss counter built only when PLL_SUP_LOSS_COUNT_EN is defined
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int PLLRST_CYCLES = DEF_PLLRST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 LOCKED_ASYNC,
    input  logic                 SOFT_RESET,
    output logic                 PLL_RST,
    output logic                 RESET_OUT,
    output logic                 READY,
    output logic [CNT_WIDTH-1:0] LOSS_COUNT
);

    localparam int TW = timer_width(STABLE_CYCLES, PLLRST_CYCLES, LOCK_TIMEOUT);

    localparam logic [TW-1:0] PLLRST_LAST  = TW'(PLLRST_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);

    pll_sup_state_t state;
    pll_sup_state_t nxt_state;
    logic [TW-1:0]  timer;
    logic           lock_s;
    logic           restart_timer;

    sync_2ff u_lock_sync (
        .clk (CLK),
        .rst (RESET),
        .d   (LOCKED_ASYNC),
        .q   (lock_s)
    );

    // Next-state selection; a soft reset overrides every other transition.
    always_comb begin
        nxt_state = state;
        if (SOFT_RESET) begin
            nxt_state = S_PLLRST;
        end else begin
            case (state)
                S_PLLRST: begin
                    if (timer == PLLRST_LAST) nxt_state = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (lock_s)                     nxt_state = S_STABLE;
                    else if (timer == TIMEOUT_LAST) nxt_state = S_PLLRST;
                end
                S_STABLE: begin
                    if (!lock_s)                   nxt_state = S_WAIT_LOCK;
                    else if (timer == STABLE_LAST) nxt_state = S_RUN;
                end
                S_RUN: begin
                    if (!lock_s) nxt_state = S_PLLRST;
                end
            endcase
        end
    end

    // A soft reset while already in S_PLLRST restarts the pulse, so it also clears the timer.
    assign restart_timer = SOFT_RESET || (nxt_state != state);

    // State, shared timer and outputs; outputs decode the next state so they move with the state register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= S_PLLRST;
            timer     <= '0;
            PLL_RST   <= 1'b1;
            RESET_OUT <= 1'b1;
            READY     <= 1'b0;
        end else begin
            state     <= nxt_state;
            timer     <= restart_timer ? '0 : timer + 1'b1;
            PLL_RST   <= (nxt_state == S_PLLRST);
            RESET_OUT <= (nxt_state != S_RUN);
            READY     <= (nxt_state == S_RUN);
        end
    end

`ifdef PLL_SUP_LOSS_COUNT_EN
    logic [CNT_WIDTH-1:0] loss_q;
    logic                 loss_event;

    // A loss is a lock drop seen in S_RUN that is not masked by a simultaneous soft reset.
    assign loss_event = (state == S_RUN) && !lock_s && !SOFT_RESET;

    // Saturating lock-loss counter.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            loss_q <= '0;
        end else if (loss_event && (loss_q != {CNT_WIDTH{1'b1}})) begin
            loss_q <= loss_q + 1'b1;
        end
    end

    assign LOSS_COUNT = loss_q;
`else
    assign LOSS_COUNT = '0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - self-checking bench for pll_lock_supervisor
module tb_pll_lock_supervisor;

    localparam int PLLRST   = 16;
    localparam int STABLE   = 32;
    localparam int TIMEOUT  = 100;
    localparam int CW       = 2;
    localparam int LOSS_MAX = (1 << CW) - 1;

    logic          CLK;
    logic          RESET;
    logic          LOCKED_ASYNC;
    logic          SOFT_RESET;
    logic          PLL_RST;
    logic          RESET_OUT;
    logic          READY;
    logic [CW-1:0] LOSS_COUNT;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    pll_lock_supervisor #(
        .STABLE_CYCLES (STABLE),
        .PLLRST_CYCLES (PLLRST),
        .LOCK_TIMEOUT  (TIMEOUT),
        .CNT_WIDTH     (CW)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .LOCKED_ASYNC (LOCKED_ASYNC),
        .SOFT_RESET   (SOFT_RESET),
        .PLL_RST      (PLL_RST),
        .RESET_OUT    (RESET_OUT),
        .READY        (READY),
        .LOSS_COUNT   (LOSS_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Reference model: phase with a countdown of remaining cycles, lock seen two edges late.
    typedef enum int {P_PLLRST, P_WAIT, P_STABLE, P_RUN} phase_t;
    phase_t ph     = P_PLLRST;
    int     rem    = PLLRST;
    bit     hist0  = 0;
    bit     hist1  = 0;
    bit     ls     = 0;
    int     m_loss = 0;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ph = P_PLLRST; rem = PLLRST; hist0 = 0; hist1 = 0; m_loss = 0;
        end else begin
            ls    = hist1;
            hist1 = hist0;
            hist0 = LOCKED_ASYNC;
            if (SOFT_RESET) begin
                ph = P_PLLRST; rem = PLLRST;
            end else begin
                case (ph)
                    P_PLLRST: begin
                        rem--;
                        if (rem == 0) begin ph = P_WAIT; rem = TIMEOUT; end
                    end
                    P_WAIT: begin
                        if (ls) begin ph = P_STABLE; rem = STABLE; end
                        else begin
                            rem--;
                            if (rem == 0) begin ph = P_PLLRST; rem = PLLRST; end
                        end
                    end
                    P_STABLE: begin
                        if (!ls) begin ph = P_WAIT; rem = TIMEOUT; end
                        else begin
                            rem--;
                            if (rem == 0) ph = P_RUN;
                        end
                    end
                    P_RUN: begin
                        if (!ls) begin
                            ph = P_PLLRST; rem = PLLRST;
`ifdef PLL_SUP_LOSS_COUNT_EN
                            if (m_loss < LOSS_MAX) m_loss++;
`endif
                        end
                    end
                endcase
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("pll_rst",   PLL_RST,    32'(ph == P_PLLRST));
            check("ready",     READY,      32'(ph == P_RUN));
            check("reset_out", RESET_OUT,  32'(ph != P_RUN));
            check("loss",      LOSS_COUNT, 32'(m_loss));
        end
    end

    int hi_runs[$];
    int lo_runs[$];
    int exp_loss;
    int ready_seen;

    function automatic int bump_loss(input int v);
`ifdef PLL_SUP_LOSS_COUNT_EN
        return (v < LOSS_MAX) ? v + 1 : LOSS_MAX;
`else
        return v;
`endif
    endfunction

    initial begin
        RESET = 1'b1; LOCKED_ASYNC = 1'b1; SOFT_RESET = 1'b0;
        exp_loss = 0;
        step(3);
        chk_en = 1;
        check("rst_pll_rst", PLL_RST, 1);
        check("rst_ready", READY, 0);
        check("rst_reset_out", RESET_OUT, 1);
        check("rst_loss", LOSS_COUNT, 0);

        // Lock present throughout: PLL_RST 16 cycles, READY at edge 49.
        RESET = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            step(1);
            if (k == 15) check("pllrst_edge15", PLL_RST, 1);
            if (k == 16) check("pllrst_edge16", PLL_RST, 0);
            if (k == 48) check("ready_edge48", READY, 0);
            if (k == 49) check("ready_edge49", READY, 1);
        end
        check("loss_initial", LOSS_COUNT, 0);

        // No lock: repeating 16-high / 100-low PLL_RST pulses, never ready.
        LOCKED_ASYNC = 1'b0; SOFT_RESET = 1'b1;
        step(1);
        SOFT_RESET = 1'b0;
        begin
            logic cur;
            int   len;
            cur = PLL_RST; len = 1; ready_seen = 0;
            for (int i = 1; i < 400; i++) begin
                step(1);
                if (READY) ready_seen++;
                if (PLL_RST == cur) len++;
                else begin
                    if (cur) hi_runs.push_back(len); else lo_runs.push_back(len);
                    cur = PLL_RST; len = 1;
                end
            end
        end
        check("hi_run0", hi_runs.size() > 0 ? hi_runs[0] : 0, PLLRST);
        check("hi_run1", hi_runs.size() > 1 ? hi_runs[1] : 0, PLLRST);
        check("lo_run0", lo_runs.size() > 0 ? lo_runs[0] : 0, TIMEOUT);
        check("lo_run1", lo_runs.size() > 1 ? lo_runs[1] : 0, TIMEOUT);
        check("no_ready_unlocked", ready_seen, 0);
        check("loss_after_timeouts", LOSS_COUNT, 0);

        // One-cycle lock drop in RUN.
        LOCKED_ASYNC = 1'b1; SOFT_RESET = 1'b1;
        step(1);
        SOFT_RESET = 1'b0;
        step(59);
        check("run_before_drop", READY, 1);
        LOCKED_ASYNC = 1'b0;
        step(1);
        LOCKED_ASYNC = 1'b1;
        step(1);
        check("drop_edge2_reset_out", RESET_OUT, 0);
        step(1);
        exp_loss = bump_loss(exp_loss);
        check("drop_edge3_reset_out", RESET_OUT, 1);
        check("drop_edge3_pll_rst", PLL_RST, 1);
        check("drop_loss", LOSS_COUNT, exp_loss);
        step(60);
        check("relock_ready", READY, 1);

        // Glitch during S_STABLE: READY delayed by a full stable window.
        SOFT_RESET = 1'b1;
        step(1);
        SOFT_RESET = 1'b0;
        for (int k = 2; k <= 80; k++) begin
            step(1);
            if (k == 37) LOCKED_ASYNC = 1'b0;
            if (k == 38) LOCKED_ASYNC = 1'b1;
            if (k == 49) check("glitch_no_ready49", READY, 0);
            if (k == 72) check("glitch_ready72", READY, 0);
            if (k == 73) check("glitch_ready73", READY, 1);
        end
        check("glitch_loss", LOSS_COUNT, exp_loss);

        // Soft reset coincident with the lock drop reaching the FSM in RUN.
        LOCKED_ASYNC = 1'b0;
        step(2);
        SOFT_RESET = 1'b1;
        step(1);
        SOFT_RESET = 1'b0;
        check("soft_drop_pll_rst", PLL_RST, 1);
        check("soft_drop_loss", LOSS_COUNT, exp_loss);
        LOCKED_ASYNC = 1'b1;
        step(5);

        // Repeated losses drive the counter into saturation.
        for (int n = 0; n < 4; n++) begin
            SOFT_RESET = 1'b1;
            step(1);
            SOFT_RESET = 1'b0;
            step(59);
            check("sat_run", READY, 1);
            LOCKED_ASYNC = 1'b0;
            step(1);
            LOCKED_ASYNC = 1'b1;
            step(2);
            exp_loss = bump_loss(exp_loss);
            check("sat_loss", LOSS_COUNT, exp_loss);
        end

        // Randomised lock behaviour and sporadic soft resets, checked against the model.
        for (int i = 0; i < 3000; i++) begin
            if (LOCKED_ASYNC) begin
                if ($urandom_range(0, 149) == 0) LOCKED_ASYNC = 1'b0;
            end else begin
                if ($urandom_range(0, 29) == 0) LOCKED_ASYNC = 1'b1;
            end
            SOFT_RESET = ($urandom_range(0, 199) == 0);
            step(1);
        end
        SOFT_RESET = 1'b0;

        // Asynchronous reset mid-cycle returns everything at once.
        @(posedge CLK);
        #3 RESET = 1'b1;
        #1;
        check("async_pll_rst", PLL_RST, 1);
        check("async_ready", READY, 0);
        check("async_reset_out", RESET_OUT, 1);
        check("async_loss", LOSS_COUNT, 0);
        step(2);
        LOCKED_ASYNC = 1'b1;
        RESET = 1'b0;
        step(60);
        check("after_reset_ready", READY, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
